magia_fsync_barrier_resp: RTL and testbench

- Tile-facing responder end of the FractalSync link: the barrier unit that tiles' sync requests terminate on, in standalone mesh/TB configurations without the full FS tree.
- Latches per-tile sync requests carrying a one-hot level (TILE_FSYNC_W bits).
- Releases every tile of an aligned group with a one-cycle ack once all members have arrived at the same level.
- Flags protocol violations on a sticky error port.

---
 rtl/magia_pkg.sv | 25 ++
 rtl/magia_fsync_group_match.sv | 40 ++++
 rtl/magia_fsync_barrier_resp.sv | 98 +++++++++
 tb/tb_magia_fsync_barrier_resp.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/magia_pkg.sv
// Shared FractalSync sizing, level type and level-validity helper.
package magia_pkg;

    localparam int unsigned N_TILES      = 4;
    localparam int unsigned FSYNC_LVL    = 2;
    localparam int unsigned TILE_FSYNC_W = FSYNC_LVL;

    typedef logic [TILE_FSYNC_W-1:0] fsync_lvl_t;

    // A level is usable when it is one-hot and its group (2^(k+1) tiles) fits the mesh.
    function automatic logic fsync_lvl_valid(input fsync_lvl_t lvl, input int unsigned n_tiles);
        int unsigned n_set;
        logic        fits;
        n_set = 0;
        fits  = 1'b0;
        for (int unsigned k = 0; k < TILE_FSYNC_W; k++) begin
            if (lvl[k]) begin
                n_set++;
                fits = (k < FSYNC_LVL) && ((32'd2 << k) <= n_tiles);
            end
        end
        return (n_set == 32'd1) && fits;
    endfunction

endpackage

// File: rtl/magia_fsync_group_match.sv
// Combinational release detector: a waiting tile is done once its whole
// aligned group is waiting at the same level.
module magia_fsync_group_match
    import magia_pkg::*;
#(
    parameter int unsigned N_TILES      = magia_pkg::N_TILES,
    parameter int unsigned TILE_FSYNC_W = magia_pkg::TILE_FSYNC_W
) (
    input  logic [N_TILES-1:0]              pending_q,
    input  logic [N_TILES*TILE_FSYNC_W-1:0] lvl_q,
    output logic [N_TILES-1:0]              done_c
);

    int unsigned gmask;
    logic        match;

    always_comb begin
        done_c = '0;
        gmask  = 0;
        match  = 1'b0;
        for (int unsigned i = 0; i < N_TILES; i++) begin
            // Group size 2^(k+1) for one-hot level bit k; mask strips the in-group offset.
            gmask = 0;
            for (int unsigned k = 0; k < TILE_FSYNC_W; k++) begin
                if (lvl_q[i*TILE_FSYNC_W + k]) begin
                    gmask = (32'd2 << k) - 32'd1;
                end
            end
            match = pending_q[i];
            for (int unsigned j = 0; j < N_TILES; j++) begin
                if ((j & ~gmask) == (i & ~gmask)) begin
                    match = match & pending_q[j]
                          & (lvl_q[j*TILE_FSYNC_W +: TILE_FSYNC_W] == lvl_q[i*TILE_FSYNC_W +: TILE_FSYNC_W]);
                end
            end
            done_c[i] = match;
        end
    end

endmodule

// File: rtl/magia_fsync_barrier_resp.sv
// FractalSync responder: latches per-tile sync requests, releases aligned
// groups with a one-cycle ack, and flags protocol violations.
module magia_fsync_barrier_resp
    import magia_pkg::*;
#(
    parameter int unsigned N_TILES      = magia_pkg::N_TILES,
    parameter int unsigned FSYNC_LVL    = magia_pkg::FSYNC_LVL,
    parameter int unsigned TILE_FSYNC_W = magia_pkg::TILE_FSYNC_W
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [N_TILES-1:0]                sync_req_i,
    input  logic [N_TILES*TILE_FSYNC_W-1:0]   sync_lvl_i,
    output logic [N_TILES-1:0]                sync_ack_o,
    output logic                              busy_o,
    output logic                              err_o,
    output logic [$clog2(N_TILES)-1:0]        err_tile_o
);

    localparam int unsigned IDX_W = $clog2(N_TILES);

    if ((N_TILES < 2) || ((N_TILES & (N_TILES - 1)) != 0) || (TILE_FSYNC_W != FSYNC_LVL)) begin : g_bad_cfg
        $error("magia_fsync_barrier_resp: unsupported N_TILES/FSYNC_LVL/TILE_FSYNC_W");
    end

    logic [N_TILES-1:0]              pending_q, pending_d;
    logic [N_TILES*TILE_FSYNC_W-1:0] lvl_q, lvl_d;
    logic [N_TILES-1:0]              ack_q, ack_d;
    logic                            busy_q, busy_d;
    logic                            err_q, err_d;
    logic [IDX_W-1:0]                err_tile_q, err_tile_d;
    logic [N_TILES-1:0]              done_c;
    logic [N_TILES-1:0]              viol_c;

    magia_fsync_group_match #(
        .N_TILES      (N_TILES),
        .TILE_FSYNC_W (TILE_FSYNC_W)
    ) u_group_match (
        .pending_q (pending_q),
        .lvl_q     (lvl_q),
        .done_c    (done_c)
    );

    // Capture, release and error bookkeeping.
    always_comb begin
        pending_d  = pending_q & ~done_c;
        lvl_d      = lvl_q;
        ack_d      = done_c;
        viol_c     = '0;
        err_d      = err_q;
        err_tile_d = err_tile_q;
        for (int unsigned i = 0; i < N_TILES; i++) begin
            if (sync_req_i[i]) begin
                // A tile still waiting (even one being released this cycle) may not re-request.
                if (pending_q[i]
                    || !fsync_lvl_valid(fsync_lvl_t'(sync_lvl_i[i*TILE_FSYNC_W +: TILE_FSYNC_W]), N_TILES)) begin
                    viol_c[i] = 1'b1;
                end else begin
                    pending_d[i]                            = 1'b1;
                    lvl_d[i*TILE_FSYNC_W +: TILE_FSYNC_W]   = sync_lvl_i[i*TILE_FSYNC_W +: TILE_FSYNC_W];
                end
            end
        end
        busy_d = |pending_d;
        if (!err_q && (|viol_c)) begin
            err_d = 1'b1;
            for (int i = int'(N_TILES) - 1; i >= 0; i--) begin
                if (viol_c[i]) begin
                    err_tile_d = IDX_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q  <= '0;
            lvl_q      <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_tile_q <= '0;
        end else begin
            pending_q  <= pending_d;
            lvl_q      <= lvl_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            err_tile_q <= err_tile_d;
        end
    end

    assign sync_ack_o = ack_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;
    assign err_tile_o = err_tile_q;

endmodule

// File: tb/tb_magia_fsync_barrier_resp.sv
// Directed bench for magia_fsync_barrier_resp (4 tiles, 2 levels).
module tb_magia_fsync_barrier_resp;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] sync_req_i;
    logic [7:0] sync_lvl_i;
    logic [3:0] sync_ack_o;
    logic       busy_o;
    logic       err_o;
    logic [1:0] err_tile_o;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] ack_seen;

    always #5 clk_i = ~clk_i;

    magia_fsync_barrier_resp dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .sync_req_i (sync_req_i),
        .sync_lvl_i (sync_lvl_i),
        .sync_ack_o (sync_ack_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .err_tile_o (err_tile_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present req/lvl for one cycle, then land 1 time unit into the next cycle.
    task automatic cyc(input logic [3:0] req, input logic [7:0] lvl);
        sync_req_i = req;
        sync_lvl_i = lvl;
        @(posedge clk_i);
        #1;
        sync_req_i = '0;
        sync_lvl_i = '0;
    endtask

    task automatic reset_dut();
        rst_ni     = 1'b0;
        sync_req_i = '0;
        sync_lvl_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni     = 1'b0;
        sync_req_i = '0;
        sync_lvl_i = '0;
        #2;
        chk("rst_ack", 32'(sync_ack_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_err_tile", 32'(err_tile_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Level-0 pair, then re-request in the ack cycle
        cyc(4'b0011, 8'b0000_0101);
        chk("l0_c1_ack", 32'(sync_ack_o), 32'h0);
        chk("l0_c1_busy", 32'(busy_o), 32'h1);
        cyc(4'b0000, 8'h00);
        chk("l0_c2_ack", 32'(sync_ack_o), 32'h3);
        cyc(4'b0011, 8'b0000_0101);
        chk("l0_rereq_c3_ack", 32'(sync_ack_o), 32'h0);
        chk("l0_rereq_c3_busy", 32'(busy_o), 32'h1);
        cyc(4'b0000, 8'h00);
        chk("l0_rereq_c4_ack", 32'(sync_ack_o), 32'h3);
        cyc(4'b0000, 8'h00);
        chk("l0_c5_ack", 32'(sync_ack_o), 32'h0);
        chk("l0_c5_busy", 32'(busy_o), 32'h0);
        chk("l0_c5_err", 32'(err_o), 32'h0);

        // Staggered level-1 barrier: tile 3 joins in cycle 5
        for (int c = 0; c < 7; c++) begin
            cyc((c == 0) ? 4'b0111 : ((c == 5) ? 4'b1000 : 4'b0000), 8'b1010_1010);
            chk($sformatf("stag_c%0d_ack", c + 1), 32'(sync_ack_o), (c == 6) ? 32'hF : 32'h0);
        end
        cyc(4'b0000, 8'h00);
        chk("stag_after_ack", 32'(sync_ack_o), 32'h0);
        chk("stag_after_busy", 32'(busy_o), 32'h0);

        // Concurrent disjoint groups
        cyc(4'b1111, 8'b0101_0101);
        chk("conc_c1_ack", 32'(sync_ack_o), 32'h0);
        cyc(4'b0000, 8'h00);
        chk("conc_c2_ack", 32'(sync_ack_o), 32'hF);
        cyc(4'b0011, 8'b0000_0101);
        cyc(4'b1100, 8'b0101_0000);
        chk("conc_late_lo_ack", 32'(sync_ack_o), 32'h3);
        cyc(4'b0000, 8'h00);
        chk("conc_late_hi_ack", 32'(sync_ack_o), 32'hC);
        cyc(4'b0000, 8'h00);
        chk("conc_idle_busy", 32'(busy_o), 32'h0);

        // Mismatched levels in the upper pair never release
        cyc(4'b1111, 8'b1010_0101);
        cyc(4'b0000, 8'h00);
        chk("mism_c2_ack", 32'(sync_ack_o), 32'h3);
        ack_seen = '0;
        repeat (100) begin
            cyc(4'b0000, 8'h00);
            ack_seen |= sync_ack_o;
        end
        chk("mism_window_ack", 32'(ack_seen), 32'h0);
        chk("mism_busy", 32'(busy_o), 32'h1);
        chk("mism_err", 32'(err_o), 32'h0);

        // Errors: multi-hot level, then a double request while waiting
        reset_dut();
        cyc(4'b0100, 8'b0011_0000);
        chk("err_mh_err", 32'(err_o), 32'h1);
        chk("err_mh_tile", 32'(err_tile_o), 32'h2);
        chk("err_mh_busy", 32'(busy_o), 32'h0);
        cyc(4'b0010, 8'b0000_0100);
        chk("err_t1_busy", 32'(busy_o), 32'h1);
        cyc(4'b0010, 8'b0000_1000);
        chk("err_dbl_err", 32'(err_o), 32'h1);
        chk("err_dbl_tile", 32'(err_tile_o), 32'h2);
        cyc(4'b0001, 8'b0000_0001);
        cyc(4'b0000, 8'h00);
        chk("err_t1_lvl_kept_ack", 32'(sync_ack_o), 32'h3);

        // Reset mid-barrier discards waiting tiles
        cyc(4'b0111, 8'b1010_1010);
        chk("rmid_busy", 32'(busy_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("rmid_ack", 32'(sync_ack_o), 32'h0);
        chk("rmid_busy_rst", 32'(busy_o), 32'h0);
        chk("rmid_err", 32'(err_o), 32'h0);
        chk("rmid_err_tile", 32'(err_tile_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        cyc(4'b1000, 8'b1000_0000);
        ack_seen = '0;
        repeat (20) begin
            cyc(4'b0000, 8'h00);
            ack_seen |= sync_ack_o;
        end
        chk("rmid_t3_no_ack", 32'(ack_seen), 32'h0);
        chk("rmid_t3_busy", 32'(busy_o), 32'h1);

        // Simultaneous zero-level errors: lowest index is reported
        reset_dut();
        cyc(4'b1010, 8'h00);
        chk("simul_err", 32'(err_o), 32'h1);
        chk("simul_err_tile", 32'(err_tile_o), 32'h1);
        chk("simul_busy", 32'(busy_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
